writereg_encoder: RTL and testbench

Request-to-index encoder for the register-file write port; the inverse of the 5-to-32 write-select decoder. It collects per-register write requests from up to 32 producers and serialises them, one per handshake, into a 5-bit `ctrl_writeReg` index with a valid/ready handshake. Arbitration is round-robin, and pending requests are held until issued. It sits between the writeback sources and the register file's write-select decoder.

---
 rtl/writereg_encoder_pkg.sv | 16 +
 rtl/writereg_encoder_if.sv | 17 +
 rtl/writereg_encoder_rr_find_first.sv | 31 +++
 rtl/writereg_encoder.sv | 98 +++++++++
 tb/tb_writereg_encoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/writereg_encoder_pkg.sv
// Shared definitions for the register-file write-index encoder.
//   NREG       : number of request lines / registers (power of two)
//   IDX_W      : register index width, log2(NREG)
//   reg_idx_t  : register index
//   reg_mask_t : one bit per register
//   reg_cnt_t  : population count of a reg_mask_t, range 0..NREG
package writereg_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [NREG-1:0]  reg_mask_t;
  typedef logic [IDX_W:0]   reg_cnt_t;

endpackage

// File: rtl/writereg_encoder_if.sv
// Index handshake between the write-index encoder and the register file's
// write-select decoder.
//   ctrl_writeReg : issued register index
//   enc_valid     : ctrl_writeReg holds an issued index
//   enc_ready     : consumer accepts the index this cycle
// Modports: master = encoder side, slave = consumer side.
interface writereg_encoder_if;
  import writereg_pkg::*;

  reg_idx_t ctrl_writeReg;
  logic     enc_valid;
  logic     enc_ready;

  modport master (output ctrl_writeReg, output enc_valid, input enc_ready);
  modport slave  (input ctrl_writeReg, input enc_valid, output enc_ready);

endinterface

// File: rtl/writereg_encoder_rr_find_first.sv
// Round-robin first-set-bit finder.
//   mask  : candidate bits
//   ptr   : scan start position; scan goes upward and wraps NREG-1 -> 0
//   sel   : first set bit found at or after ptr
//   found : mask has at least one bit set
module rr_find_first
  import writereg_pkg::*;
(
  input  reg_mask_t mask,
  input  reg_idx_t  ptr,
  output reg_idx_t  sel,
  output logic      found
);

  reg_idx_t idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      // IDX_W-bit addition wraps modulo NREG since NREG is a power of two
      idx = ptr + reg_idx_t'(i);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writereg_encoder.sv
// Register-file write-index encoder: collects per-register write requests
// and issues them one at a time as a register index over a valid/ready
// handshake, arbitrating round-robin among pending requests.
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset
//   req_in     : per-register write request pulses (any number per cycle)
//   enc        : index handshake (master side)
//   pending    : requests captured but not yet loaded into the output stage
//   pend_count : population count of pending
// Build option: WRITEREG_ENC_SKIP_R0_EN masks req_in[0] so register 0 is
// never pending, issued or counted.
module writereg_encoder
  import writereg_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  reg_mask_t                 req_in,
  writereg_encoder_if.master        enc,
  output reg_mask_t                 pending,
  output reg_cnt_t                  pend_count
);

  reg_mask_t pending_q, pending_d;
  reg_mask_t req_eff;
  reg_mask_t load_mask;
  reg_idx_t  ctrl_q, ctrl_d;
  reg_idx_t  ptr_q, ptr_d;
  reg_idx_t  sel;
  logic      valid_q, valid_d;
  logic      found;
  logic      load;
  reg_cnt_t  count_q, count_d;

  // Selection looks at registered pending only, so a request is never
  // selectable in the cycle it arrives.
  rr_find_first u_find (
    .mask  (pending_q),
    .ptr   (ptr_q),
    .sel   (sel),
    .found (found)
  );

  always_comb begin
    req_eff = req_in;
`ifdef WRITEREG_ENC_SKIP_R0_EN
    req_eff[0] = 1'b0;
`else
`endif
  end

  always_comb begin
    load      = found & (~valid_q | enc.enc_ready);
    load_mask = '0;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;

    if (load) begin
      load_mask[sel] = 1'b1;
      ctrl_d         = sel;
      valid_d        = 1'b1;
      ptr_d          = sel + reg_idx_t'(1);
    end else if (valid_q & enc.enc_ready) begin
      // Transfer with nothing left to load; index keeps its last value.
      valid_d = 1'b0;
    end

    // Set wins over clear: a re-request of the index being loaded stays pending.
    pending_d = (pending_q & ~load_mask) | req_eff;

    count_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      count_d = count_d + reg_cnt_t'(pending_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

  assign enc.ctrl_writeReg = ctrl_q;
  assign enc.enc_valid     = valid_q;
  assign pending           = pending_q;
  assign pend_count        = count_q;

endmodule

// File: tb/tb_writereg_encoder.sv
// Self-checking bench for writereg_encoder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of pending set, pointer and output stage.
module tb_writereg_encoder;
  import writereg_pkg::*;

  logic      clock = 1'b0;
  logic      reset_n = 1'b0;
  reg_mask_t req_in = '0;
  reg_mask_t pending;
  reg_cnt_t  pend_count;

  writereg_encoder_if bus ();

  writereg_encoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_in     (req_in),
    .enc        (bus.master),
    .pending    (pending),
    .pend_count (pend_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

`ifdef WRITEREG_ENC_SKIP_R0_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend[NREG];
  int m_ptr = 0;
  bit m_valid = 1'b0;
  int m_idx = 0;
  int issued[$];
  int chosen;

  always @(posedge clock) begin
    if (!reset_n) begin
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_ptr = 0;
      m_valid = 1'b0;
      m_idx = 0;
    end else begin
      if (m_valid && bus.enc_ready) issued.push_back(m_idx);
      chosen = -1;
      if (!m_valid || bus.enc_ready)
        for (int k = 0; k < NREG; k++)
          if (chosen < 0 && m_pend[(m_ptr + k) % NREG]) chosen = (m_ptr + k) % NREG;
      if (chosen >= 0) begin
        m_idx = chosen;
        m_valid = 1'b1;
        m_pend[chosen] = 1'b0;
        m_ptr = (chosen + 1) % NREG;
      end else if (m_valid && bus.enc_ready) begin
        m_valid = 1'b0;
      end
      for (int k = 0; k < NREG; k++)
        if (req_in[k] && !(SKIP0 && k == 0)) m_pend[k] = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  reg_mask_t exp_p;
  int exp_c;

  always @(negedge clock) begin
    if (check_en) begin
      exp_c = 0;
      for (int k = 0; k < NREG; k++) begin
        exp_p[k] = m_pend[k];
        exp_c += int'(m_pend[k]);
      end
      check("cyc_pending", pending, exp_p);
      check("cyc_pend_count", 32'(pend_count), 32'(exp_c));
      check("cyc_enc_valid", 32'(bus.enc_valid), 32'(m_valid));
      check("cyc_ctrl_writeReg", 32'(bus.ctrl_writeReg), 32'(m_idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_in = '0;
    tick();
    reset_n = 1'b1;
    issued.delete();
  endtask

  initial begin
    bus.enc_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    check("rst_pending", pending, 32'h0);
    check("rst_valid", 32'(bus.enc_valid), 32'h0);
    check("rst_count", 32'(pend_count), 32'h0);
    check("rst_ctrl", 32'(bus.ctrl_writeReg), 32'h0);

    // single request
    reset_n = 1'b1;
    req_in = 32'h0000_0010;
    tick();
    check("single_count1", 32'(pend_count), 32'd1);
    check("single_valid_c1", 32'(bus.enc_valid), 32'd0);
    req_in = '0;
    tick();
    check("single_valid_c2", 32'(bus.enc_valid), 32'd1);
    check("single_idx", 32'(bus.ctrl_writeReg), 32'd4);
    check("single_count0", 32'(pend_count), 32'd0);

    // burst with wrap
    do_reset();
    req_in = 32'h8000_0006;
    tick();
    check("burst_count", 32'(pend_count), 32'd3);
    req_in = '0;
    tick(); check("burst_i0", 32'(bus.ctrl_writeReg), 32'd1);
    tick(); check("burst_i1", 32'(bus.ctrl_writeReg), 32'd2);
    tick(); check("burst_i2", 32'(bus.ctrl_writeReg), 32'd31);
    tick(); check("burst_drained", 32'(bus.enc_valid), 32'd0);
    req_in = 32'h0000_0001;
    tick();
    req_in = '0;
    tick();
    tick();
    check("burst_nissued", 32'(issued.size()), SKIP0 ? 32'd3 : 32'd4);
    if (issued.size() >= 3) begin
      check("burst_ord0", 32'(issued[0]), 32'd1);
      check("burst_ord1", 32'(issued[1]), 32'd2);
      check("burst_ord2", 32'(issued[2]), 32'd31);
    end
    if (!SKIP0 && issued.size() >= 4) check("burst_wrap", 32'(issued[3]), 32'd0);

    // backpressure
    do_reset();
    bus.enc_ready = 1'b0;
    req_in = 32'h0000_0109;
    tick();
    req_in = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_ctrl", 32'(bus.ctrl_writeReg), SKIP0 ? 32'd3 : 32'd0);
      check("bp_count", 32'(pend_count), SKIP0 ? 32'd1 : 32'd2);
      check("bp_valid", 32'(bus.enc_valid), 32'd1);
      tick();
    end
    bus.enc_ready = 1'b1;
    tick(); tick(); tick();
    check("bp_drain_valid", 32'(bus.enc_valid), 32'd0);
    check("bp_drain_count", 32'(pend_count), 32'd0);

    // set wins over clear
    do_reset();
    req_in = 32'h0000_0080;
    tick();
    tick();
    check("svc_pend7", 32'(pending[7]), 32'd1);
    check("svc_first", 32'(bus.ctrl_writeReg), 32'd7);
    req_in = '0;
    tick();
    check("svc_second_valid", 32'(bus.enc_valid), 32'd1);
    check("svc_second_idx", 32'(bus.ctrl_writeReg), 32'd7);
    tick();
    tick();
    check("svc_nissued", 32'(issued.size()), 32'd2);

    // full
    do_reset();
    bus.enc_ready = 1'b0;
    req_in = '1;
    tick();
    check("full_count", 32'(pend_count), SKIP0 ? 32'd31 : 32'd32);
    req_in = '0;
    tick();
    check("full_count_load", 32'(pend_count), SKIP0 ? 32'd30 : 32'd31);
    check("full_first_idx", 32'(bus.ctrl_writeReg), SKIP0 ? 32'd1 : 32'd0);
    bus.enc_ready = 1'b1;
    for (int i = 0; i < 35; i++) tick();
    check("full_nissued", 32'(issued.size()), SKIP0 ? 32'd31 : 32'd32);
    if (issued.size() > 0) check("full_last", 32'(issued[issued.size() - 1]), 32'd31);
    foreach (issued[k]) if (SKIP0 && issued[k] == 0) check("full_r0_issued", 32'(issued[k]), 32'd1);
    check("full_empty_valid", 32'(bus.enc_valid), 32'd0);

    // mid-operation reset
    do_reset();
    bus.enc_ready = 1'b0;
    req_in = 32'h000F_F700;
    tick();
    req_in = '0;
    tick();
    check("mid_count", 32'(pend_count), 32'd10);
    reset_n = 1'b0;
    req_in = 32'h0000_0400;
    tick();
    check("mid_pending", pending, 32'h0);
    check("mid_valid", 32'(bus.enc_valid), 32'd0);
    check("mid_count0", 32'(pend_count), 32'd0);
    reset_n = 1'b1;
    issued.delete();
    bus.enc_ready = 1'b1;
    req_in = 32'h0010_0008;
    tick();
    req_in = '0;
    tick();
    check("mid_first_from0", 32'(bus.ctrl_writeReg), 32'd3);
    tick(); tick();
    check("mid_nissued", 32'(issued.size()), 32'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) req_in = '1;
      else req_in = $urandom & $urandom & $urandom;
      bus.enc_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    req_in = '0;
    bus.enc_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("rand_end_valid", 32'(bus.enc_valid), 32'd0);
    check("rand_end_count", 32'(pend_count), 32'd0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
